// File: rtl/control_sequencer.sv
// control_sequencer: multi-cycle fetch/decode/execute controller driving a dataPath.
// Fetches RV32I words over a req/valid port, decodes ADDI/ADD/BNE, owns the PC.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   imem_req/imem_addr         fetch request and address (address = pc)
//   imem_rdata/imem_valid      fetched word and its strobe (honoured only in FETCH)
//   EQ                         operand-equality from the dataPath ALU (used by BNE)
//   rs1/rs2/rd                 register indices to the dataPath
//   RegWrite/ALUsrc/ImmOp      write enable, op2 select, sign-extended immediate
//   pc                         current program counter
//   halt                       sticky illegal-instruction flag
module control_sequencer #(
  parameter int unsigned ADDRESS_WIDTH = 5,
  parameter int unsigned DATA_WIDTH    = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  output logic                     imem_req,
  output logic [DATA_WIDTH-1:0]    imem_addr,
  input  logic [DATA_WIDTH-1:0]    imem_rdata,
  input  logic                     imem_valid,
  input  logic                     EQ,
  output logic [ADDRESS_WIDTH-1:0] rs1,
  output logic [ADDRESS_WIDTH-1:0] rs2,
  output logic [ADDRESS_WIDTH-1:0] rd,
  output logic                     RegWrite,
  output logic                     ALUsrc,
  output logic [DATA_WIDTH-1:0]    ImmOp,
  output logic [DATA_WIDTH-1:0]    pc,
  output logic                     halt
);

  localparam logic [1:0] ST_FETCH  = 2'd0;
  localparam logic [1:0] ST_DECODE = 2'd1;
  localparam logic [1:0] ST_EXEC   = 2'd2;
  localparam logic [1:0] ST_HALT   = 2'd3;

  // Instruction class captured at fetch; reset value matches the NOP (ADDI x0,x0,0).
  localparam logic [1:0] K_ALU = 2'd0;
  localparam logic [1:0] K_BNE = 2'd1;
  localparam logic [1:0] K_ILL = 2'd2;

  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [DATA_WIDTH-1:0] PC_STEP = DATA_WIDTH'(4);

  logic [1:0]               state, state_next;
  logic [1:0]               kind, kind_next;
  logic [DATA_WIDTH-1:0]    pc_next;
  logic [ADDRESS_WIDTH-1:0] rs1_next, rs2_next, rd_next;
  logic [DATA_WIDTH-1:0]    imm_next;
  logic                     alu_src_next;
  logic                     reg_write_next;
  logic                     imem_req_next;
  logic                     halt_next;

  logic [1:0]               dec_kind;
  logic                     dec_alu_src;
  logic [DATA_WIDTH-1:0]    dec_imm;

  assign imem_addr = pc;

  // Decode of the incoming memory word; captured only when a fetch is accepted.
  always_comb begin
    dec_kind    = K_ILL;
    dec_alu_src = 1'b0;
    dec_imm     = '0;
    if (imem_rdata[6:0] == OP_IMM && imem_rdata[14:12] == 3'b000) begin
      dec_kind = K_ALU;
      dec_imm  = {{(DATA_WIDTH-12){imem_rdata[31]}}, imem_rdata[31:20]};
    end else if (imem_rdata[6:0] == OP_REG && imem_rdata[14:12] == 3'b000 &&
                 imem_rdata[31:25] == 7'b0000000) begin
      dec_kind    = K_ALU;
      dec_alu_src = 1'b1;
    end else if (imem_rdata[6:0] == OP_BRANCH && imem_rdata[14:12] == 3'b001) begin
      dec_kind    = K_BNE;
      dec_alu_src = 1'b1;
      dec_imm     = {{(DATA_WIDTH-13){imem_rdata[31]}}, imem_rdata[31], imem_rdata[7],
                     imem_rdata[30:25], imem_rdata[11:8], 1'b0};
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_next     = state;
    kind_next      = kind;
    pc_next        = pc;
    rs1_next       = rs1;
    rs2_next       = rs2;
    rd_next        = rd;
    imm_next       = ImmOp;
    alu_src_next   = ALUsrc;
    case (state)
      ST_FETCH: begin
        // imem_req is low for the first cycle out of reset, so no fetch is accepted then.
        if (imem_req && imem_valid) begin
          state_next   = ST_DECODE;
          kind_next    = dec_kind;
          rs1_next     = ADDRESS_WIDTH'(imem_rdata[19:15]);
          rs2_next     = ADDRESS_WIDTH'(imem_rdata[24:20]);
          rd_next      = ADDRESS_WIDTH'(imem_rdata[11:7]);
          imm_next     = dec_imm;
          alu_src_next = dec_alu_src;
        end
      end
      ST_DECODE: state_next = (kind == K_ILL) ? ST_HALT : ST_EXEC;
      ST_EXEC: begin
        state_next = ST_FETCH;
        if (kind == K_BNE && !EQ) pc_next = pc + ImmOp;
        else                      pc_next = pc + PC_STEP;
      end
      ST_HALT:  state_next = ST_HALT;
      default:  state_next = ST_HALT;
    endcase
    imem_req_next  = (state_next == ST_FETCH);
    halt_next      = (state_next == ST_HALT);
    // RegWrite is registered, so it is raised while leaving DECODE and is high during EXEC only.
    reg_write_next = (state == ST_DECODE) && (kind == K_ALU) && (rd != '0);
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_FETCH;
    else        state <= state_next;
  end

  // Registered datapath controls and PC.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc       <= RESET_PC;
      kind     <= K_ALU;
      rs1      <= '0;
      rs2      <= '0;
      rd       <= '0;
      ImmOp    <= '0;
      ALUsrc   <= 1'b0;
      RegWrite <= 1'b0;
      imem_req <= 1'b0;
      halt     <= 1'b0;
    end else begin
      pc       <= pc_next;
      kind     <= kind_next;
      rs1      <= rs1_next;
      rs2      <= rs2_next;
      rd       <= rd_next;
      ImmOp    <= imm_next;
      ALUsrc   <= alu_src_next;
      RegWrite <= reg_write_next;
      imem_req <= imem_req_next;
      halt     <= halt_next;
    end
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Testbench for control_sequencer: acts as instruction memory and dataPath EQ source,
// predicts every cycle from an instruction-level model, and compares on the falling edge.
module tb_control_sequencer;

  localparam int unsigned AW = 5;
  localparam int unsigned DW = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          imem_req;
  logic [DW-1:0] imem_addr;
  logic [DW-1:0] imem_rdata = '0;
  logic          imem_valid = 1'b0;
  logic          EQ = 1'b0;
  logic [AW-1:0] rs1, rs2, rd;
  logic          RegWrite, ALUsrc;
  logic [DW-1:0] ImmOp, pc;
  logic          halt;

  control_sequencer #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata), .imem_valid(imem_valid),
    .EQ(EQ), .rs1(rs1), .rs2(rs2), .rd(rd),
    .RegWrite(RegWrite), .ALUsrc(ALUsrc), .ImmOp(ImmOp), .pc(pc), .halt(halt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Per-cycle expectations written by the driver, consumed at the falling edge.
  bit          chk_on = 1'b0;
  bit          chk_req = 1'b0;
  bit          chk_fields = 1'b0;
  logic        exp_req = 1'b0, exp_rw = 1'b0, exp_halt = 1'b0, exp_alusrc = 1'b0;
  logic [31:0] exp_pc = '0, exp_imm = '0;
  logic [4:0]  exp_rs1 = '0, exp_rs2 = '0, exp_rd = '0;
  logic [31:0] mpc = '0;
  int          rw_pulses = 0;
  logic [31:0] seen_imm = '0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
    end
  endtask

  // Model: 0 illegal, 1 ADDI, 2 ADD, 3 BNE.
  function automatic int kind_of(input logic [31:0] w);
    if (w[6:0] == 7'h13 && w[14:12] == 3'd0) return 1;
    if (w[6:0] == 7'h33 && w[14:12] == 3'd0 && w[31:25] == 7'd0) return 2;
    if (w[6:0] == 7'h63 && w[14:12] == 3'd1) return 3;
    return 0;
  endfunction

  function automatic logic [31:0] imm_of(input logic [31:0] w, input int k);
    logic [12:0] b;
    int          v;
    if (k == 1) return 32'($signed(w) >>> 20);
    if (k == 3) begin
      b = {w[31], w[7], w[30:25], w[11:8], 1'b0};
      v = int'(b);
      if (w[31]) v = v - 8192;
      return 32'(v);
    end
    return 32'h0;
  endfunction

  // Single compare process.
  always @(negedge clk) begin
    if (chk_on) begin
      check32("RegWrite", 32'(RegWrite), 32'(exp_rw));
      check32("halt", 32'(halt), 32'(exp_halt));
      check32("pc", pc, exp_pc);
      if (chk_req) begin
        check32("imem_req", 32'(imem_req), 32'(exp_req));
        if (exp_req) check32("imem_addr", imem_addr, exp_pc);
      end
      if (chk_fields) begin
        check32("rs1", 32'(rs1), 32'(exp_rs1));
        check32("rs2", 32'(rs2), 32'(exp_rs2));
        check32("rd", 32'(rd), 32'(exp_rd));
        check32("ALUsrc", 32'(ALUsrc), 32'(exp_alusrc));
        check32("ImmOp", ImmOp, exp_imm);
        seen_imm = ImmOp;
      end
    end
    if (RegWrite === 1'b1) rw_pulses++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_inputs();
    imem_valid = 1'($urandom);
    imem_rdata = $urandom;
    EQ         = 1'($urandom);
  endtask

  task automatic set_reset_exp();
    exp_req = 1'b0; exp_rw = 1'b0; exp_halt = 1'b0; exp_pc = 32'h0;
    chk_req = 1'b1; chk_fields = 1'b0; mpc = 32'h0;
  endtask

  task automatic release_reset();
    rst_n = 1'b1;
    imem_valid = 1'b0;
    chk_req = 1'b0;
    step();
    chk_req = 1'b1;
    exp_req = 1'b1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    set_reset_exp();
    repeat (3) begin rand_inputs(); step(); end
    release_reset();
  endtask

  // One instruction: stall cycles, accepting FETCH, DECODE, optionally EXEC.
  task automatic run_instr(input logic [31:0] w, input int stall, input bit eq,
                           input bit kill, output int k);
    k = kind_of(w);
    rw_pulses = 0;
    exp_rw = 1'b0; exp_halt = 1'b0; exp_pc = mpc; exp_req = 1'b1; chk_fields = 1'b0;
    for (int i = 0; i < stall; i++) begin
      imem_valid = 1'b0; imem_rdata = $urandom; EQ = 1'($urandom);
      step();
    end
    imem_valid = 1'b1; imem_rdata = w; EQ = 1'($urandom);
    step();
    rand_inputs();
    exp_req = 1'b0;
    chk_fields = (k != 0);
    exp_rs1 = w[19:15]; exp_rs2 = w[24:20]; exp_rd = w[11:7];
    exp_alusrc = (k == 2 || k == 3);
    exp_imm = imm_of(w, k);
    step();
    if (k != 0) begin
      rand_inputs();
      EQ = eq;
      exp_rw = (k == 1 || k == 2) && (w[11:7] != 5'd0);
      if (kill) begin
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check32("kill_RegWrite", 32'(RegWrite), 32'h0);
        check32("kill_pc", pc, 32'h0);
        check32("kill_req", 32'(imem_req), 32'h0);
        set_reset_exp();
        step();
        step();
        release_reset();
      end else begin
        step();
        mpc = (k == 3 && !eq) ? mpc + imm_of(w, k) : mpc + 32'd4;
        exp_rw = 1'b0; chk_fields = 1'b0; exp_req = 1'b1; exp_pc = mpc;
      end
    end
  endtask

  task automatic halt_cycles(input int n);
    exp_req = 1'b0; exp_rw = 1'b0; exp_halt = 1'b1; exp_pc = mpc; chk_fields = 1'b0;
    for (int i = 0; i < n; i++) begin rand_inputs(); step(); end
  endtask

  initial begin
    int          k;
    logic [31:0] w;
    int          sel;

    set_reset_exp();
    chk_on = 1'b1;
    do_reset();
    check32("rst_pc", pc, 32'h0);
    check32("rst_req", 32'(imem_req), 32'h1);
    check32("rst_addr", imem_addr, 32'h0);
    check32("rst_regwrite", 32'(RegWrite), 32'h0);
    check32("rst_halt", 32'(halt), 32'h0);

    run_instr(32'h00500093, 0, 1'b0, 1'b0, k);
    check32("addi_pc", pc, 32'd4);
    check32("addi_imm", seen_imm, 32'd5);
    check32("addi_pulses", 32'(rw_pulses), 32'd1);

    run_instr(32'h002081B3, 3, 1'b0, 1'b0, k);
    check32("add_pc", pc, 32'd8);
    check32("add_imm", seen_imm, 32'd0);
    check32("add_pulses", 32'(rw_pulses), 32'd1);

    run_instr(32'hFE009CE3, 0, 1'b0, 1'b0, k);
    check32("bne_taken_imm", seen_imm, 32'hFFFFFFF8);
    check32("bne_taken_pc", pc, 32'd0);
    check32("bne_taken_pulses", 32'(rw_pulses), 32'd0);

    run_instr(32'h00500093, 1, 1'b0, 1'b0, k);
    run_instr(32'h002081B3, 0, 1'b0, 1'b0, k);
    run_instr(32'hFE009CE3, 2, 1'b1, 1'b0, k);
    check32("bne_fall_pc", pc, 32'd12);
    check32("bne_fall_pulses", 32'(rw_pulses), 32'd0);

    run_instr(32'h00100013, 0, 1'b0, 1'b0, k);
    check32("addi_x0_pc", pc, 32'd16);
    check32("addi_x0_pulses", 32'(rw_pulses), 32'd0);

    run_instr(32'hFFFFFFFF, 1, 1'b0, 1'b0, k);
    halt_cycles(5);
    check32("halt_flag", 32'(halt), 32'h1);
    check32("halt_req", 32'(imem_req), 32'h0);
    check32("halt_pc", pc, 32'd16);

    do_reset();
    run_instr(32'h00500093, 0, 1'b0, 1'b1, k);
    check32("post_kill_addr", imem_addr, 32'h0);
    check32("post_kill_pulses", 32'(rw_pulses), 32'd1);
    run_instr(32'h002081B3, 0, 1'b0, 1'b0, k);
    check32("post_kill_pc", pc, 32'd4);

    // Randomized instruction stream with stalls, EQ and occasional illegal words.
    for (int n = 0; n < 250; n++) begin
      sel = int'($urandom_range(0, 9));
      w = $urandom;
      if (sel <= 2) begin
        w[6:0] = 7'h13; w[14:12] = 3'd0;
      end else if (sel <= 5) begin
        w[6:0] = 7'h33; w[14:12] = 3'd0; w[31:25] = 7'd0;
      end else if (sel <= 8) begin
        w[6:0] = 7'h63; w[14:12] = 3'd1;
      end else begin
        while (kind_of(w) != 0) w = $urandom;
      end
      if (sel <= 5 && $urandom_range(0, 5) == 0) w[11:7] = 5'd0;
      run_instr(w, int'($urandom_range(0, 3)), 1'($urandom), 1'b0, k);
      if (k == 0) begin
        halt_cycles(int'($urandom_range(1, 4)));
        do_reset();
      end
    end

    chk_on = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
